// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Load hits complete in the request cycle; misses and stores run a req/ack memory transaction.
module dcache_controller #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 4
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iReq,
   input  logic                  iWrite,
   input  logic [3:0]            iByteEn,
   input  logic [ADDR_WIDTH-1:0] iAddress,
   input  logic [DATA_WIDTH-1:0] iWData,
   input  logic                  iFlush,
   output logic [DATA_WIDTH-1:0] oRData,
   output logic                  oStall,
   output logic                  oMemReq,
   output logic                  oMemWrite,
   output logic [ADDR_WIDTH-1:0] oMemAddress,
   output logic [DATA_WIDTH-1:0] oMemWData,
   output logic [3:0]            oMemByteEn,
   input  logic                  iMemAck,
   input  logic [DATA_WIDTH-1:0] iMemRData,
   output logic [15:0]           oHitCount,
   output logic [15:0]           oMissCount
);

   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_LSB   = INDEX_WIDTH + 2;
   localparam int TAG_WIDTH = ADDR_WIDTH - TAG_LSB;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] WR_WAIT = 2'd2;

   logic [1:0]            state;
   logic [LINES-1:0]      valid;
   logic [TAG_WIDTH-1:0]  tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES];

   logic                  mem_req;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [3:0]            mem_byte_en;
   logic [15:0]           hit_count;
   logic [15:0]           miss_count;

   logic [INDEX_WIDTH-1:0] req_index;
   logic [INDEX_WIDTH-1:0] lat_index;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic [TAG_WIDTH-1:0]   lat_tag;
   logic                   req_hit;
   logic                   lat_hit;
   logic                   load_hit;
   logic                   load_miss;
   logic                   store_start;
   logic                   rd_done;
   logic                   wr_done;
   logic                   stall;
   logic [DATA_WIDTH-1:0]  rdata;
   logic                   unused_addr_bits;

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [3:0]            lanes
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (lanes[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

   assign req_index = iAddress[TAG_LSB-1:2];
   assign req_tag   = iAddress[ADDR_WIDTH-1:TAG_LSB];
   assign lat_index = mem_address[TAG_LSB-1:2];
   assign lat_tag   = mem_address[ADDR_WIDTH-1:TAG_LSB];

   // The store merge re-checks the latched address at ack time, so a flush or refill in between is honoured.
   assign req_hit = valid[req_index] && (tag_mem[req_index] == req_tag);
   assign lat_hit = valid[lat_index] && (tag_mem[lat_index] == lat_tag);

   assign load_hit    = (state == IDLE) && iReq && !iWrite && req_hit;
   assign load_miss   = (state == IDLE) && iReq && !iWrite && !req_hit;
   assign store_start = (state == IDLE) && iReq && iWrite;
   assign rd_done     = (state == RD_WAIT) && iMemAck;
   assign wr_done     = (state == WR_WAIT) && iMemAck;

   assign unused_addr_bits = ^iAddress[1:0];

   always_comb begin
      stall = 1'b0;
      rdata = '0;
      case (state)
         IDLE: begin
            stall = iReq && (iWrite || !req_hit);
            if (load_hit) rdata = data_mem[req_index];
         end
         RD_WAIT: begin
            stall = !iMemAck;
            if (iMemAck) rdata = iMemRData;
         end
         WR_WAIT: stall = !iMemAck;
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state       <= IDLE;
         valid       <= '0;
         mem_req     <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
         mem_byte_en <= '0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_miss) begin
                  state       <= RD_WAIT;
                  mem_req     <= 1'b1;
                  mem_write   <= 1'b0;
                  mem_address <= {iAddress[ADDR_WIDTH-1:2], 2'b00};
                  mem_byte_en <= '0;
               end else if (store_start) begin
                  state       <= WR_WAIT;
                  mem_req     <= 1'b1;
                  mem_write   <= 1'b1;
                  mem_address <= {iAddress[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata   <= iWData;
                  mem_byte_en <= iByteEn;
               end
            end
            RD_WAIT, WR_WAIT: begin
               if (iMemAck) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               mem_req   <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase

         if (load_hit && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
         if (load_miss && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;

         // Flush beats a same-edge refill, leaving the freshly written line invalid.
         if (iFlush) valid <= '0;
         else if (rd_done) valid[lat_index] <= 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst) begin
         if (rd_done) begin
            tag_mem[lat_index]  <= lat_tag;
            data_mem[lat_index] <= iMemRData;
         end else if (wr_done && lat_hit) begin
            data_mem[lat_index] <= merge_bytes(data_mem[lat_index], mem_wdata, mem_byte_en);
         end
      end
   end

   assign oRData      = rdata;
   assign oStall      = stall;
   assign oMemReq     = mem_req;
   assign oMemWrite   = mem_write;
   assign oMemAddress = mem_address;
   assign oMemWData   = mem_wdata;
   assign oMemByteEn  = mem_byte_en;
   assign oHitCount   = hit_count;
   assign oMissCount  = miss_count;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random traffic
// compared against a word-level cache/memory reference model.
module tb_dcache_controller;

   logic        iClk      = 1'b0;
   logic        iRst      = 1'b1;
   logic        iReq      = 1'b0;
   logic        iWrite    = 1'b0;
   logic [3:0]  iByteEn   = '0;
   logic [31:0] iAddress  = '0;
   logic [31:0] iWData    = '0;
   logic        iFlush    = 1'b0;
   logic        iMemAck   = 1'b0;
   logic [31:0] iMemRData = '0;
   logic [31:0] oRData;
   logic        oStall;
   logic        oMemReq;
   logic        oMemWrite;
   logic [31:0] oMemAddress;
   logic [31:0] oMemWData;
   logic [3:0]  oMemByteEn;
   logic [15:0] oHitCount;
   logic [15:0] oMissCount;

   always #5 iClk = ~iClk;

   dcache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_WIDTH(4)) dut (
      .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWrite(iWrite), .iByteEn(iByteEn),
      .iAddress(iAddress), .iWData(iWData), .iFlush(iFlush), .oRData(oRData),
      .oStall(oStall), .oMemReq(oMemReq), .oMemWrite(oMemWrite), .oMemAddress(oMemAddress),
      .oMemWData(oMemWData), .oMemByteEn(oMemByteEn), .iMemAck(iMemAck), .iMemRData(iMemRData),
      .oHitCount(oHitCount), .oMissCount(oMissCount)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Reference model: backing memory keyed by word address, cache contents per index.
   logic [31:0] mem_model [int unsigned];
   bit          m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_data  [16];
   int          m_hits   = 0;
   int          m_misses = 0;
   logic [31:0] exp_rdata;
   bit          exp_hit;

   int          obs_stall;
   bit          obs_timeout;
   bit          obs_req_seen;
   bit          obs_unstable;
   logic        obs_req_after;
   logic [31:0] obs_rdata;
   logic [31:0] obs_maddr;
   logic [31:0] obs_mwdata;
   logic        obs_mwrite;
   logic [3:0]  obs_mbe;

   function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] addr);
      int unsigned key;
      key = addr[31:2];
      if (!mem_model.exists(key)) mem_model[key] = $urandom;
      return mem_model[key];
   endfunction

   task automatic model_flush();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
   endtask

   task automatic model_reset();
      model_flush();
      m_hits   = 0;
      m_misses = 0;
   endtask

   // flush_when: 0 none, 1 in the request cycle, 2 in the memory ack cycle.
   task automatic model_access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input int flush_when);
      int idx;
      logic [25:0] tg;
      idx = int'(addr[5:2]);
      tg = addr[31:6];
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_rdata = '0;
      if (!wr) begin
         if (exp_hit) begin
            exp_rdata = m_data[idx];
            if (m_hits < 65535) m_hits++;
         end else begin
            exp_rdata = mem_read(addr);
            if (m_misses < 65535) m_misses++;
         end
      end
      if (flush_when == 1) model_flush();
      if (!wr && !exp_hit) begin
         m_tag[idx]  = tg;
         m_data[idx] = exp_rdata;
         m_valid[idx] = 1'b1;
      end
      if (wr) begin
         mem_model[addr[31:2]] = merge_word(mem_read(addr), wdata, be);
         if (m_valid[idx] && (m_tag[idx] == tg)) m_data[idx] = merge_word(m_data[idx], wdata, be);
      end
      if (flush_when == 2 && !(!wr && exp_hit)) model_flush();
   endtask

   // Drives one request and acts as the memory; ack_delay = non-ack WAIT cycles before the ack.
   task automatic run_access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input int ack_delay, input int flush_when);
      int waits;
      waits = 0;
      obs_stall = 0; obs_timeout = 1'b1; obs_req_seen = 1'b0; obs_unstable = 1'b0;
      obs_rdata = '0; obs_maddr = '0; obs_mwdata = '0; obs_mwrite = 1'b0; obs_mbe = '0;
      @(negedge iClk);
      iReq = 1'b1; iWrite = wr; iAddress = addr; iByteEn = be; iWData = wdata;
      iMemAck = 1'b0; iMemRData = $urandom; iFlush = (flush_when == 1);
      for (int c = 0; c < 64; c++) begin
         if (c > 0) begin
            @(negedge iClk);
            iFlush = 1'b0; iMemAck = 1'b0; iMemRData = $urandom;
            if (oMemReq) begin
               if (!obs_req_seen) begin
                  obs_req_seen = 1'b1;
                  obs_maddr = oMemAddress; obs_mwdata = oMemWData;
                  obs_mwrite = oMemWrite; obs_mbe = oMemByteEn;
               end else if ({oMemAddress, oMemWData, oMemWrite, oMemByteEn} !==
                            {obs_maddr, obs_mwdata, obs_mwrite, obs_mbe}) begin
                  obs_unstable = 1'b1;
               end
               if (waits == ack_delay) begin
                  iMemAck = 1'b1;
                  iMemRData = mem_read(addr);
                  iFlush = (flush_when == 2);
               end
               waits++;
            end
         end
         #1;
         if (!oStall) begin
            obs_rdata = oRData;
            obs_timeout = 1'b0;
            break;
         end
         obs_stall++;
      end
      @(posedge iClk);
      #1;
      obs_req_after = oMemReq;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge iClk);
         iReq = 1'b0;
         iMemAck = 1'($urandom_range(0, 1));
         iMemRData = $urandom;
         iFlush = ($urandom_range(0, 7) == 0);
         if (iFlush) model_flush();
      end
      @(negedge iClk);
      iMemAck = 1'b0;
      iFlush = 1'b0;
   endtask

   task automatic test_reset();
      iRst = 1'b1; iReq = 1'b0;
      repeat (2) @(negedge iClk);
      #1;
      vectors++; if (oStall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %b expected 0", oStall); end
      vectors++; if (oMemReq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_memreq: got %b expected 0", oMemReq); end
      vectors++; if (oMemWrite !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_memwrite: got %b expected 0", oMemWrite); end
      vectors++; if ({oMemAddress, oMemWData, oMemByteEn} !== 68'd0) begin miscompares++; $display("[TB] FAIL reset_memfields: got %h/%h/%h expected 0", oMemAddress, oMemWData, oMemByteEn); end
      vectors++; if (oRData !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", oRData); end
      vectors++; if ({oHitCount, oMissCount} !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", oHitCount, oMissCount); end
      iReq = 1'b1; iWrite = 1'b0; iAddress = 32'h100;
      #1;
      vectors++; if (oStall !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_load_stall: got %b expected 1", oStall); end
      @(negedge iClk);
      iReq = 1'b0; iRst = 1'b0;
      model_reset();
   endtask

   task automatic test_load_miss_hit();
      mem_model[32'h100 >> 2] = 32'hDEADBEEF;
      model_access(1'b0, 32'h100, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h100, 4'hF, 32'h0, 3, 0);
      vectors++; if (obs_timeout) begin miscompares++; $display("[TB] FAIL miss_timeout: got stuck expected completion"); end
      vectors++; if (obs_stall !== 4) begin miscompares++; $display("[TB] FAIL miss_stall: got %0d expected 4", obs_stall); end
      vectors++; if (obs_maddr !== 32'h100 || obs_mwrite !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_memaddr: got %h w=%b expected 00000100 w=0", obs_maddr, obs_mwrite); end
      vectors++; if (obs_rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL miss_rdata: got %h expected deadbeef", obs_rdata); end
      vectors++; if (obs_unstable || obs_req_after !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_req_drop: got unstable=%b req_after=%b expected 0/0", obs_unstable, obs_req_after); end
      model_access(1'b0, 32'h100, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h100, 4'hF, 32'h0, 0, 0);
      vectors++; if (obs_stall !== 0) begin miscompares++; $display("[TB] FAIL hit_stall: got %0d expected 0", obs_stall); end
      vectors++; if (obs_rdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL hit_rdata: got %h expected deadbeef", obs_rdata); end
      vectors++; if (oHitCount !== 16'd1 || oMissCount !== 16'd1) begin miscompares++; $display("[TB] FAIL hit_counters: got %0d/%0d expected 1/1", oHitCount, oMissCount); end
      idle(1);
   endtask

   task automatic test_store_merge();
      model_access(1'b1, 32'h102, 4'b0100, 32'h00AA0000, 0);
      run_access(1'b1, 32'h102, 4'b0100, 32'h00AA0000, 1, 0);
      vectors++; if (obs_stall !== 2) begin miscompares++; $display("[TB] FAIL store_stall: got %0d expected 2", obs_stall); end
      vectors++; if (obs_mwrite !== 1'b1 || obs_mbe !== 4'b0100) begin miscompares++; $display("[TB] FAIL store_lanes: got w=%b be=%b expected w=1 be=0100", obs_mwrite, obs_mbe); end
      vectors++; if (obs_maddr !== 32'h100 || obs_mwdata !== 32'h00AA0000) begin miscompares++; $display("[TB] FAIL store_fields: got %h/%h expected 00000100/00aa0000", obs_maddr, obs_mwdata); end
      vectors++; if (obs_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL store_rdata: got %h expected 0", obs_rdata); end
      model_access(1'b0, 32'h100, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h100, 4'hF, 32'h0, 0, 0);
      vectors++; if (obs_stall !== 0 || obs_rdata !== 32'hDEAABEEF) begin miscompares++; $display("[TB] FAIL merged_hit: got stall=%0d data=%h expected 0/deaabeef", obs_stall, obs_rdata); end
      idle(1);
   endtask

   task automatic test_store_no_allocate();
      model_access(1'b1, 32'h200, 4'hF, 32'h12345678, 0);
      run_access(1'b1, 32'h200, 4'hF, 32'h12345678, 0, 0);
      vectors++; if (obs_stall !== 1) begin miscompares++; $display("[TB] FAIL noalloc_store_stall: got %0d expected 1", obs_stall); end
      model_access(1'b0, 32'h200, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h200, 4'hF, 32'h0, 2, 0);
      vectors++; if (obs_stall !== 3 || obs_rdata !== 32'h12345678) begin miscompares++; $display("[TB] FAIL noalloc_load: got stall=%0d data=%h expected 3/12345678", obs_stall, obs_rdata); end
      vectors++; if (oMissCount !== 16'd2) begin miscompares++; $display("[TB] FAIL noalloc_misses: got %0d expected 2", oMissCount); end
      idle(1);
   endtask

   task automatic test_aliasing();
      logic [31:0] seq [3];
      int misses_before;
      int d;
      seq[0] = 32'h100; seq[1] = 32'h140; seq[2] = 32'h100;
      misses_before = m_misses;
      for (int k = 0; k < 3; k++) begin
         d = $urandom_range(0, 3);
         model_access(1'b0, seq[k], 4'hF, 32'h0, 0);
         run_access(1'b0, seq[k], 4'hF, 32'h0, d, 0);
         vectors++; if (obs_stall !== 1 + d || obs_rdata !== mem_read(seq[k])) begin miscompares++; $display("[TB] FAIL alias_%0d: got stall=%0d data=%h expected %0d/%h", k, obs_stall, obs_rdata, 1 + d, mem_read(seq[k])); end
      end
      vectors++; if (oMissCount !== 16'(misses_before + 3)) begin miscompares++; $display("[TB] FAIL alias_misses: got %0d expected %0d", oMissCount, misses_before + 3); end
      idle(1);
   endtask

   task automatic test_flush_refill();
      model_access(1'b0, 32'h104, 4'hF, 32'h0, 2);
      run_access(1'b0, 32'h104, 4'hF, 32'h0, 1, 2);
      vectors++; if (obs_stall !== 2 || obs_rdata !== mem_read(32'h104)) begin miscompares++; $display("[TB] FAIL flush_ack_load: got stall=%0d data=%h expected 2/%h", obs_stall, obs_rdata, mem_read(32'h104)); end
      model_access(1'b0, 32'h104, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h104, 4'hF, 32'h0, 0, 0);
      vectors++; if (obs_stall !== 1) begin miscompares++; $display("[TB] FAIL flush_ack_remiss: got stall=%0d expected 1", obs_stall); end
      model_access(1'b0, 32'h104, 4'hF, 32'h0, 1);
      run_access(1'b0, 32'h104, 4'hF, 32'h0, 0, 1);
      vectors++; if (obs_stall !== 0 || obs_rdata !== mem_read(32'h104)) begin miscompares++; $display("[TB] FAIL flush_idle_hit: got stall=%0d data=%h expected 0/%h", obs_stall, obs_rdata, mem_read(32'h104)); end
      model_access(1'b0, 32'h104, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h104, 4'hF, 32'h0, 0, 0);
      vectors++; if (obs_stall !== 1) begin miscompares++; $display("[TB] FAIL flush_idle_remiss: got stall=%0d expected 1", obs_stall); end
      idle(1);
   endtask

   task automatic test_back_to_back();
      bit          wr_seq [4];
      logic [31:0] wd;
      int          exp_stall;
      wr_seq[0] = 1'b0; wr_seq[1] = 1'b0; wr_seq[2] = 1'b1; wr_seq[3] = 1'b0;
      wd = $urandom;
      for (int k = 0; k < 4; k++) begin
         model_access(wr_seq[k], 32'h010, 4'b1001, wd, 0);
         exp_stall = (!wr_seq[k] && exp_hit) ? 0 : 1;
         run_access(wr_seq[k], 32'h010, 4'b1001, wd, 0, 0);
         vectors++; if (obs_stall !== exp_stall || obs_rdata !== exp_rdata) begin miscompares++; $display("[TB] FAIL b2b_%0d: got stall=%0d data=%h expected %0d/%h", k, obs_stall, obs_rdata, exp_stall, exp_rdata); end
      end
      idle(1);
   endtask

   task automatic test_reset_mid();
      model_access(1'b0, 32'h0C8, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h0C8, 4'hF, 32'h0, 0, 0);
      @(negedge iClk);
      iReq = 1'b1; iWrite = 1'b0; iAddress = 32'h1C8; iMemAck = 1'b0; iFlush = 1'b0;
      @(negedge iClk);
      #1;
      vectors++; if (oMemReq !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pending: got %b expected 1", oMemReq); end
      @(negedge iClk);
      iRst = 1'b1; iReq = 1'b0; iMemAck = 1'b1; iMemRData = $urandom;
      @(posedge iClk);
      #1;
      vectors++; if (oMemReq !== 1'b0 || oStall !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_req: got req=%b stall=%b expected 0/0", oMemReq, oStall); end
      vectors++; if ({oHitCount, oMissCount} !== 32'd0) begin miscompares++; $display("[TB] FAIL rstmid_counters: got %0d/%0d expected 0/0", oHitCount, oMissCount); end
      @(negedge iClk);
      iRst = 1'b0; iMemAck = 1'b0;
      model_reset();
      model_access(1'b0, 32'h1C8, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h1C8, 4'hF, 32'h0, 1, 0);
      vectors++; if (obs_stall !== 2 || obs_rdata !== mem_read(32'h1C8)) begin miscompares++; $display("[TB] FAIL rstmid_reload: got stall=%0d data=%h expected 2/%h", obs_stall, obs_rdata, mem_read(32'h1C8)); end
      model_access(1'b0, 32'h0C8, 4'hF, 32'h0, 0);
      run_access(1'b0, 32'h0C8, 4'hF, 32'h0, 0, 0);
      vectors++; if (obs_stall !== 1) begin miscompares++; $display("[TB] FAIL rstmid_old_line: got stall=%0d expected 1", obs_stall); end
      vectors++; if (oMissCount !== 16'd2 || oHitCount !== 16'd0) begin miscompares++; $display("[TB] FAIL rstmid_count_after: got %0d/%0d expected 0/2", oHitCount, oMissCount); end
      idle(1);
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      bit          wr;
      int          d;
      int          fw;
      int          r;
      int          exp_stall;
      for (int n = 0; n < 200; n++) begin
         addr = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | ($urandom & 32'h0000_00FF);
         wr = ($urandom_range(0, 9) < 3);
         be = 4'($urandom_range(1, 15));
         wd = $urandom;
         d = $urandom_range(0, 3);
         r = $urandom_range(0, 15);
         fw = (r == 0) ? 1 : (r == 1) ? 2 : 0;
         model_access(wr, addr, be, wd, fw);
         exp_stall = (!wr && exp_hit) ? 0 : 1 + d;
         run_access(wr, addr, be, wd, d, fw);
         vectors++; if (obs_timeout || obs_stall !== exp_stall) begin miscompares++; $display("[TB] FAIL rand_stall_%0d: got %0d (timeout=%b) expected %0d", n, obs_stall, obs_timeout, exp_stall); end
         vectors++; if (obs_rdata !== exp_rdata) begin miscompares++; $display("[TB] FAIL rand_rdata_%0d: got %h expected %h addr %h", n, obs_rdata, exp_rdata, addr); end
         if (exp_stall != 0) begin
            vectors++; if (obs_maddr !== {addr[31:2], 2'b00} || obs_mwrite !== wr) begin miscompares++; $display("[TB] FAIL rand_mem_%0d: got %h w=%b expected %h w=%b", n, obs_maddr, obs_mwrite, {addr[31:2], 2'b00}, wr); end
            vectors++; if (obs_unstable || obs_req_after !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_hold_%0d: got unstable=%b req_after=%b expected 0/0", n, obs_unstable, obs_req_after); end
         end
         if (wr) begin
            vectors++; if (obs_mbe !== be || obs_mwdata !== wd) begin miscompares++; $display("[TB] FAIL rand_wfields_%0d: got %b/%h expected %b/%h", n, obs_mbe, obs_mwdata, be, wd); end
         end
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
      end
      vectors++; if (oHitCount !== 16'(m_hits) || oMissCount !== 16'(m_misses)) begin miscompares++; $display("[TB] FAIL rand_counters: got %0d/%0d expected %0d/%0d", oHitCount, oMissCount, m_hits, m_misses); end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting dcache_controller bench");
      test_reset();
      test_load_miss_hit();
      test_store_merge();
      test_store_no_allocate();
      test_aliasing();
      test_flush_refill();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data-cache controller sitting between the pipeline memory stage and the backing data memory. It owns the tag/valid/data arrays and sequences every miss refill and store write-through over a request/acknowledge handshake with variable-latency memory. It stalls the pipeline while a transaction is outstanding. Byte/half selection and sign/zero extension of loads stay in the memory stage; this block always returns whole words.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, byte-address width
- INDEX_WIDTH, 4, line index bits (2**INDEX_WIDTH one-word lines); tag = ADDR_WIDTH-INDEX_WIDTH-2 bits (26)
- iClk  in  1  clock, all state on rising edge
- iRst  in  1  synchronous, active-high reset
- iReq  in  1  pipeline access valid; held with all request fields until a cycle with oStall=0
- iWrite  in  1  1 = store, 0 = load
- iByteEn  in  4  store byte lanes (bit0 = bits 7:0); ignored for loads
- iAddress  in  ADDR_WIDTH  byte address; bits 1:0 ignored
- iWData  in  DATA_WIDTH  store data, already lane-aligned
- iFlush  in  1  one-cycle pulse: invalidate every line
- oRData  out  DATA_WIDTH  load word, valid in the cycle oStall=0 for a load
- oStall  out  1  combinational; 1 = pipeline must hold
- oMemReq  out  1  memory transaction valid
- oMemWrite  out  1  1 = write transaction
- oMemAddress  out  ADDR_WIDTH  word-aligned (bits 1:0 = 0)
- oMemWData  out  DATA_WIDTH  write data
- oMemByteEn  out  4  write lanes
- iMemAck  in  1  transaction complete; read data valid same cycle
- iMemRData  in  DATA_WIDTH  read data
- oHitCount  out  16  saturating load-hit counter
- oMissCount  out  16  saturating load-miss counter

## Operation
- States: IDLE, RD_WAIT, WR_WAIT.
- Hit = valid[index] && tag[index]==iAddress tag field.
- IDLE, no iReq: oStall=0, no memory activity.
- IDLE, load hit: oRData = data[index], oStall=0, oHitCount+1; stay IDLE.
- IDLE, load miss: oStall=1; latch word address; oMissCount+1; -> RD_WAIT.
- IDLE, store (hit or miss): oStall=1; latch address, iWData, iByteEn; -> WR_WAIT.
- RD_WAIT: oMemReq=1, oMemWrite=0. oStall = ~iMemAck. On iMemAck: oRData=iMemRData; line written (tag, data, valid=1); -> IDLE.
- WR_WAIT: oMemReq=1, oMemWrite=1, oMemByteEn = latched lanes. oStall = ~iMemAck. On iMemAck: if latched address hits, merge enabled bytes into the cached word (valid/tag unchanged); miss does not allocate; -> IDLE.
- iFlush: all valid bits cleared at that edge. Flush coinciding with a refill: flush wins, line stays invalid, load still completes with iMemRData. Flush coinciding with a store merge: line invalid. Flush in IDLE with a load the same cycle: that lookup uses pre-flush state.
- Counters saturate at 16'hFFFF; stores never counted.
- oRData when not returning a load: 0.

## Timing
- Reset: state IDLE, all valid=0, oMemReq=0, oMemWrite=0, oMemAddress=0, oMemWData=0, oMemByteEn=0, oRData=0, counters=0; oStall=0 unless iReq. Tag/data arrays are not reset.
- Load hit: 0 added cycles (completes in request cycle).
- Load miss / store: detect cycle + N cycles in WAIT; completes in the iMemAck cycle; minimum total 2 cycles (ack in first WAIT cycle).
- oMemReq and all oMem* fields are registered and stable from the first WAIT cycle through the ack cycle inclusive; oMemReq drops the cycle after ack.
- iMemAck ignored while oMemReq=0.
- Back-to-back: new request accepted in the cycle after an ack (IDLE); no request is looked up during the ack cycle.
- Reset mid-transaction: transaction abandoned, oMemReq=0 the following cycle, no array update.

## Test plan
- Reset, load 0x100 (miss), memory acks after 3 cycles with 0xDEADBEEF -> oStall high 4 cycles, oMemAddress=0x100, oRData=0xDEADBEEF on ack; repeat load -> 0-cycle hit, oHitCount=1, oMissCount=1.
- Cached 0x100=0xDEADBEEF; store byte 0x102, iByteEn=0100, iWData=0x00AA0000 -> oMemWrite=1, oMemByteEn=0100; after ack load 0x100 hits with 0xDEAABEEF.
- Store to uncached 0x200 then load 0x200 -> store does not allocate; load misses (oMissCount+1).
- Aliasing: load 0x100 then 0x140 (same index 0) then 0x100 -> three misses, each refill replaces line 0.
- iFlush in same cycle as refill ack for 0x104 -> load returns data, next load 0x104 misses again.
- Assert iRst during RD_WAIT -> oMemReq=0 next cycle, counters 0, next load to that address misses.
